// File: rtl/handshake_rx_fifo.sv
// Receive side of the RTS/CTS router link: one-cycle CTS pulse per flit,
// flits captured into a small show-ahead FIFO popped by the crossbar.

module handshake_rx_fifo_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module handshake_rx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RTS_in,
  output logic                     CTS_out,
  input  logic [DATA_WIDTH-1:0]    RX,
  input  logic                     read_en,
  output logic [DATA_WIDTH-1:0]    Data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          cts_nxt;
  logic          wr, rd;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full FIFO silently drops a write; it cannot occur since CTS is gated by full.
  assign wr = RTS_in & CTS_out & ~full;
  assign rd = read_en & ~empty;

  // CTS never stays high two cycles in a row, so each grant moves exactly one flit.
  assign cts_nxt = RTS_in & ~CTS_out & ~full;

  always_comb begin
    count_nxt = count;
    case ({wr, rd})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      CTS_out <= 1'b0;
    end else begin
      CTS_out <= cts_nxt;
      count   <= count_nxt;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_entry
      handshake_rx_fifo_entry #(.W(DATA_WIDTH)) u_entry (
        .clk (clk),
        .rst (rst),
        .we  (wr && (wr_ptr == AW'(i))),
        .d   (RX),
        .q   (mem[i])
      );
    end
  endgenerate

  assign Data_out = mem[rd_ptr];
endmodule

// File: tb/tb_handshake_rx_fifo.sv
// Directed bench for handshake_rx_fifo; accepted flits go to a scoreboard
// queue and a monitor checks every pop against it.

module tb_handshake_rx_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        RTS_in;
  logic        CTS_out;
  logic [31:0] RX;
  logic        read_en;
  logic [31:0] Data_out;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  handshake_rx_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .RTS_in   (RTS_in),
    .CTS_out  (CTS_out),
    .RX       (RX),
    .read_en  (read_en),
    .Data_out (Data_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: sample just after the falling edge, i.e. the values the next rising edge pops.
  always begin
    @(negedge clk);
    #1;
    if (rst && read_en && !empty) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected act=%h exp=none", Data_out);
      end else begin
        chk("pop_data", Data_out, sb.pop_front());
      end
    end
  end

  // One full RTS/CTS handshake with the arbiter's drop cycle; optional pop on the transfer cycle.
  task automatic send(input logic [31:0] v, input logic pop);
    RTS_in = 1'b1;
    RX     = v;
    @(negedge clk);
    chk("send_cts_hi", {31'd0, CTS_out}, 32'd1);
    read_en = pop;
    sb.push_back(v);
    @(negedge clk);
    chk("send_cts_lo", {31'd0, CTS_out}, 32'd0);
    RTS_in  = 1'b0;
    read_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_n(input int n);
    read_en = 1'b1;
    repeat (n) @(negedge clk);
    read_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; RTS_in = 1'b0; read_en = 1'b0; RX = '0;
    repeat (2) @(negedge clk);
    chk("rst_cts",   {31'd0, CTS_out}, 32'd0);
    chk("rst_empty", {31'd0, empty},   32'd1);
    chk("rst_full",  {31'd0, full},    32'd0);
    chk("rst_count", {29'd0, count},   32'd0);
    chk("rst_data",  Data_out,         32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single flit
    send(32'hA5A5_0001, 1'b0);
    chk("single_count", {29'd0, count}, 32'd1);
    chk("single_data",  Data_out,       32'hA5A5_0001);
    pop_n(1);
    chk("single_empty", {31'd0, empty}, 32'd1);

    // Fill to full with RTS held high: one flit every two cycles
    RTS_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      RX = 32'(i);
      @(negedge clk);
      chk("fill_cts_hi", {31'd0, CTS_out}, 32'd1);
      sb.push_back(32'(i));
      @(negedge clk);
      chk("fill_cts_lo", {31'd0, CTS_out}, 32'd0);
    end
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_head",  Data_out,       32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("full_cts_held", {31'd0, CTS_out}, 32'd0);
    end

    // Full release: pop, then CTS on the following edge, flit 5 wraps to entry 0
    RX = 32'd5;
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    chk("rel_full",  {31'd0, full},    32'd0);
    chk("rel_count", {29'd0, count},   32'd3);
    chk("rel_head",  Data_out,         32'd2);
    chk("rel_cts0",  {31'd0, CTS_out}, 32'd0);
    @(negedge clk);
    chk("rel_cts1",  {31'd0, CTS_out}, 32'd1);
    sb.push_back(32'd5);
    @(negedge clk);
    RTS_in = 1'b0;
    chk("rel_cts2",  {31'd0, CTS_out}, 32'd0);
    chk("rel_count4",{29'd0, count},   32'd4);
    pop_n(4);
    chk("rel_empty", {31'd0, empty},   32'd1);

    // Simultaneous write and pop at count=2, then at count=0
    send(32'd10, 1'b0);
    send(32'd11, 1'b0);
    send(32'd12, 1'b1);
    chk("sim2_count", {29'd0, count}, 32'd2);
    chk("sim2_head",  Data_out,       32'd11);
    pop_n(2);
    send(32'd13, 1'b1);
    chk("sim0_count", {29'd0, count}, 32'd1);
    chk("sim0_head",  Data_out,       32'd13);
    pop_n(1);

    // Underflow is ignored
    pop_n(2);
    chk("under_count", {29'd0, count}, 32'd0);
    chk("under_empty", {31'd0, empty}, 32'd1);

    // RTS dropped during the CTS cycle: no write
    RTS_in = 1'b1;
    RX = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_cts_hi", {31'd0, CTS_out}, 32'd1);
    RTS_in = 1'b0;
    @(negedge clk);
    chk("abort_cts_lo", {31'd0, CTS_out}, 32'd0);
    chk("abort_count",  {29'd0, count},   32'd0);
    chk("abort_empty",  {31'd0, empty},   32'd1);

    // Reset mid-handshake with three flits stored
    send(32'd21, 1'b0);
    send(32'd22, 1'b0);
    send(32'd23, 1'b0);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    RTS_in = 1'b1;
    RX = 32'd24;
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_cts",   {31'd0, CTS_out}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty},   32'd1);
    chk("mid_rst_full",  {31'd0, full},    32'd0);
    chk("mid_rst_count", {29'd0, count},   32'd0);
    chk("mid_rst_data",  Data_out,         32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cts", {31'd0, CTS_out}, 32'd1);
    sb.push_back(32'd24);
    @(negedge clk);
    RTS_in = 1'b0;
    chk("post_rst_cts_lo", {31'd0, CTS_out}, 32'd0);
    chk("post_rst_count",  {29'd0, count},   32'd1);
    pop_n(1);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/handshake_rx_fifo.md
# handshake_rx_fifo

Receive end of the RTS/DCTS link driven by an output-port arbiter: it sits at each router input port, answers the upstream RTS with a one-cycle clear-to-send pulse, and captures one flit per completed handshake into a small FIFO. It presents the head flit show-ahead to the local crossbar and routing logic, which pop it with a read enable. Flow control is credit-free: CTS is withheld while the FIFO is full.

## Interface
- DATA_WIDTH, 32, flit width in bits
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- RTS_in  input  1  request-to-send from the upstream arbiter's RTS
- CTS_out  output  1  clear-to-send to the upstream arbiter's DCTS input; registered
- RX  input  DATA_WIDTH  flit from upstream; sampled only on a handshake cycle
- read_en  input  1  pop request from the crossbar side (OR of grants for this port)
- Data_out  output  DATA_WIDTH  head flit; combinational from storage
- empty  output  1  FIFO holds 0 flits
- full  output  1  FIFO holds DEPTH flits
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- **Handshake.**
  - A transfer occurs on any cycle where RTS_in=1 and CTS_out=1. In that cycle RX is written at the write pointer.
  - If RTS_in=0 while CTS_out=1, no write occurs.
- **CTS next-state.** CTS_out next = 1 only if RTS_in=1, CTS_out=0 and full=0; otherwise 0.
  - CTS_out is therefore a single-cycle pulse per flit and never stays high for two consecutive cycles.
  - The upstream arbiter drops RTS for at least one cycle after each handshake.
- **Write.** Write pointer increments mod DEPTH and count increments, unless a pop happens in the same cycle.
- **Read.**
  - A pop occurs when read_en=1 and empty=0; the read pointer increments mod DEPTH.
  - read_en while empty is ignored, with no pointer or count change.
- **Simultaneous write and pop.** Count is unchanged and both pointers advance.
  - If empty at that cycle, only the write takes effect and the pop is ignored.
- **Overflow.** Overflow is impossible by construction: CTS is granted only when not full, and a write lands in the following cycle. Count never exceeds DEPTH.
  - If a write is ever attempted with full=1, it is dropped and count is unchanged (defensive behaviour).
- **Status outputs.**
  - empty = (count==0); full = (count==DEPTH); both are derived from registered count.
  - Data_out = mem[read pointer]. It is valid whenever empty=0, and its value while empty is don't-care.
- **Reset (rst=0, asynchronous).**
  - Pointers=0, count=0, CTS_out=0, empty=1, full=0.
  - Storage cleared to 0, so Data_out=0 after reset.
  - Reset mid-handshake discards any in-flight flit and all stored flits.

## Timing
- CTS latency: RTS_in sampled high at edge N (with not full) gives CTS_out=1 after edge N. The write occurs at edge N+1 if RTS_in is still 1, and CTS_out returns to 0 after edge N+1.
- Write-to-visible latency: a flit written at edge N appears on Data_out, with empty=0, after edge N.
- Pop: Data_out advances to the next entry after the edge that samples read_en=1.
- Pointer wrap: index DEPTH-1 increments to 0 with no bubble.
- Full release: a pop at edge N gives full=0 after edge N. A new CTS can be issued at edge N+1 at the earliest.
- Back-to-back rate:
  - With RTS_in held high continuously, at most one flit every 2 cycles.
  - With the arbiter's RTS drop cycle, one flit every 3 cycles.

## Test plan
- **Reset:** assert rst=0 mid-operation with count=3 -> immediately CTS_out=0, empty=1, count=0, Data_out=0; release rst, RTS_in=1 -> CTS_out=1 one edge later.
- **Single flit:** RTS_in=1, RX=0xA5A5_0001 -> CTS_out high exactly 1 cycle, then count=1 and Data_out=0xA5A5_0001; read_en for 1 cycle -> empty=1.
- **Fill to full:** hold RTS_in=1 with RX=1,2,3,4 and no reads -> 4 CTS pulses, full=1, count=4; RTS_in stays 1 -> CTS_out stays 0.
- **Full release:** from full, one pop -> Data_out=2; CTS_out pulses on the next edge; the 5th flit (5) lands and wraps to index 0; popping 2,3,4,5 yields that order.
- **Simultaneous write and pop:** count=2 and read_en=1 on the handshake cycle -> count stays 2 and order is preserved; the same test at count=0 -> count becomes 1 and the pop is ignored.
- **Underflow and aborted RTS:** read_en=1 while empty -> no change; RTS_in drops during the CTS cycle -> no write and count unchanged.
